axis_rr_arbiter: RTL
====================

// Module: axis_rr_arbiter
// PURPOSE
//  Shares one AXI-stream sink among NUM_SRC AXI-stream sources using round-robin or fixed priority.
//  Sits between the external stream sources and the CPU-side stream input peripheral.
//  Holds each grant for up to MAX_BURST beats.
//  Tags the forwarded data with the source index.
//  The CPU configures and monitors it through memory-mapped registers at SOC_SEGMENT/SOC_CLASS.
// PARAMETERS
//  SOC_SEGMENT      'He4  address bits [31:24] that select this block
//  SOC_CLASS        'Ha1  address bits [23:16] that select this block
//  AXIS_DATA_WIDTH  8     width of each stream data word
//  NUM_SRC          4     number of sources; legal range 2..4
//  MAX_BURST        4     maximum beats per grant; legal range 1..255
// PORTS
//  axis_aclk_i      in   1                    clock
//  axis_aresetn_i   in   1                    asynchronous active-low reset
//  addr_i           in   32                   CPU address
//  data_i           in   32                   CPU write data
//  data_w_i         in   1                    CPU write strobe
//  data_o           out  32                   registered CPU read data
//  data_access_o    out  1                    combinational address decode hit
//  s_axis_tvalid_i  in   NUM_SRC              per-source valid
//  s_axis_tdata_i   in   NUM_SRC*DW           source k occupies bits [k*DW +: DW]
//  s_axis_tready_o  out  NUM_SRC              per-source ready
//  m_axis_tvalid_o  out  1                    merged valid
//  m_axis_tdata_o   out  DW                   merged data
//  m_axis_tid_o     out  2                    index of the granted source
//  m_axis_tready_i  in   1                    sink ready
// BEHAVIOUR
//  Reset values (all asynchronous)
//   - data_o = 0, ctrl = 0 (all sources disabled, round-robin mode), beat_cnt = 0.
//   - State = IDLE, grant = 0, last = NUM_SRC-1, burst counter = 0.
//   - s_axis_tready_o = 0, m_axis_tvalid_o = 0, m_axis_tdata_o = 0, m_axis_tid_o = 0.
//  Register map (decoded on addr_i[6:4]; reads are registered, 1-cycle latency)
//   - 0x00 CTRL (RW)
//       bits[NUM_SRC-1:0] enable mask; bit 8 mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
//       Written when data_access_o & data_w_i.
//   - 0x10 STATUS (RO)
//       bits[NUM_SRC-1:0] raw s_axis_tvalid_i; bits[9:8] grant; bit 12 busy (state == GRANT);
//       bits[23:16] beats in the current burst.
//   - 0x20 BEATS (RO)
//       32-bit count of completed m-side handshakes; wraps 0xFFFFFFFF -> 0.
//       Any write to 0x20 clears it; a clear wins over a same-cycle increment.
//   - Other offsets read 0; writes to them are ignored.
//  State machine
//   - IDLE
//       Candidates = s_axis_tvalid_i & enable mask.
//       None: remain in IDLE.
//       Otherwise register grant, then go to GRANT on the next edge:
//         round-robin picks the first candidate searching last+1, last+2, ... modulo NUM_SRC;
//         fixed priority picks the lowest candidate index.
//       Burst counter is cleared on entry to GRANT.
//   - GRANT (combinational pass-through of the granted source g)
//       m_axis_tvalid_o = s_axis_tvalid_i[g]
//       m_axis_tdata_o  = source g data
//       m_axis_tid_o    = g
//       s_axis_tready_o[g] = m_axis_tready_i; all other ready bits are 0.
//       Beat = tvalid & tready on the m side; each beat increments the burst counter.
//   - GRANT -> IDLE (set last = g) when any of the following holds:
//       (a) a beat occurs and burst counter == MAX_BURST-1;
//       (b) s_axis_tvalid_i[g] == 0 (checked only when no beat is in flight);
//       (c) CTRL enable bit g is cleared.
//     If (c) occurs, all outputs drop in the same cycle as the CTRL write takes effect (the cycle after the write strobe).
//   - IDLE costs one cycle per re-arbitration; peak throughput = MAX_BURST/(MAX_BURST+1).
//  Protocol rules
//   - No source's tready is asserted unless that source is granted.
//   - m_axis_tvalid_o is never asserted in IDLE.
//   - A beat is never duplicated or dropped across a grant change.
//   - Granted tdata/tid are stable while m_axis_tvalid_o=1 and m_axis_tready_i=0, provided the source obeys AXIS.
//  Reset mid-burst: all outputs return to reset values immediately; the partial burst is abandoned.
// TESTING
//  1. Reset; write CTRL=0x0F; hold all 4 tvalid=1 with m_tready=1, MAX_BURST=4
//     -> tid sequence 0,0,0,0,1,1,1,1,2,...; one idle cycle between groups.
//  2. Fixed priority (CTRL=0x10F); sources 1 and 3 both valid
//     -> source 1 is always granted; source 3 is starved while source 1 stays valid.
//  3. m_tready held low 5 cycles during a grant
//     -> m_tvalid stays 1, tdata stable, s_tready[g]=0, burst counter unchanged.
//  4. Granted source drops tvalid after 2 beats
//     -> return to IDLE; the next enabled requester is granted; STATUS[23:16] reads 2 before the release.
//  5. Clear enable of the granted source mid-burst
//     -> outputs deassert the cycle after the write; no beat is accepted from that source afterwards.
//  6. Run 10 beats, read 0x20 -> 10; write 0x20 -> reads 0; assert reset mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// Round-robin / fixed-priority AXI-stream arbiter that merges NUM_SRC sources onto one sink.
// A CPU register window controls the enables and mode and reports status and beat counts.
module axis_rr_lane #(
  parameter logic [1:0] IDX = 2'd0
) (
  input  logic [1:0] grant,
  input  logic       active,
  input  logic       tvalid,
  input  logic       en,
  input  logic       m_tready,
  output logic       tready,
  output logic       cand
);
  assign tready = active && (grant == IDX) && m_tready;
  assign cand   = tvalid && en;
endmodule

module axis_rr_arbiter #(
  parameter logic [7:0] SOC_SEGMENT     = 8'he4,
  parameter logic [7:0] SOC_CLASS       = 8'ha1,
  parameter int         AXIS_DATA_WIDTH = 8,
  parameter int         NUM_SRC         = 4,
  parameter int         MAX_BURST       = 4
) (
  input  logic                               axis_aclk_i,
  input  logic                               axis_aresetn_i,
  input  logic [31:0]                        addr_i,
  input  logic [31:0]                        data_i,
  input  logic                               data_w_i,
  output logic [31:0]                        data_o,
  output logic                               data_access_o,
  input  logic [NUM_SRC-1:0]                 s_axis_tvalid_i,
  input  logic [NUM_SRC*AXIS_DATA_WIDTH-1:0] s_axis_tdata_i,
  output logic [NUM_SRC-1:0]                 s_axis_tready_o,
  output logic                               m_axis_tvalid_o,
  output logic [AXIS_DATA_WIDTH-1:0]         m_axis_tdata_o,
  output logic [1:0]                         m_axis_tid_o,
  input  logic                               m_axis_tready_i
);
  localparam int DW = AXIS_DATA_WIDTH;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [1:0]         grant, grant_nxt, last, last_nxt, pick;
  logic [7:0]         burst, burst_nxt;
  logic [NUM_SRC-1:0] en, cand;
  logic               mode, active, beat, wr_en;
  logic [31:0]        beat_cnt, rdata;
  logic [2:0]         reg_sel;

  assign data_access_o = (addr_i[31:24] == SOC_SEGMENT) && (addr_i[23:16] == SOC_CLASS);
  assign wr_en         = data_access_o && data_w_i;
  assign reg_sel       = addr_i[6:4];

  // Outputs qualify on the live enable so a CTRL clear cuts the grant immediately.
  assign active          = (state == GRANT) && en[grant];
  assign m_axis_tvalid_o = active && s_axis_tvalid_i[grant];
  assign m_axis_tdata_o  = active ? s_axis_tdata_i[grant*DW +: DW] : '0;
  assign m_axis_tid_o    = active ? grant : 2'd0;
  assign beat            = m_axis_tvalid_o && m_axis_tready_i;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_lane
    axis_rr_lane #(.IDX(2'(k))) u_lane (
      .grant    (grant),
      .active   (active),
      .tvalid   (s_axis_tvalid_i[k]),
      .en       (en[k]),
      .m_tready (m_axis_tready_i),
      .tready   (s_axis_tready_o[k]),
      .cand     (cand[k])
    );
  end

  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    pick  = 2'd0;
    if (mode) begin
      for (int i = NUM_SRC-1; i >= 0; i--)
        if (cand[i]) pick = 2'(i);
    end else begin
      for (int i = 1; i <= NUM_SRC; i++) begin
        idx = (int'(last) + i) % NUM_SRC;
        if (!found && cand[idx]) begin
          pick  = 2'(idx);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    burst_nxt = burst;
    case (state)
      IDLE: if (|cand) begin
        grant_nxt = pick;
        burst_nxt = 8'd0;
        state_nxt = GRANT;
      end
      GRANT: begin
        if (!en[grant]) begin
          state_nxt = IDLE;
          last_nxt  = grant;
        end else if (beat) begin
          burst_nxt = burst + 8'd1;
          if (burst == 8'(MAX_BURST-1)) begin
            state_nxt = IDLE;
            last_nxt  = grant;
          end
        end else if (!s_axis_tvalid_i[grant]) begin
          state_nxt = IDLE;
          last_nxt  = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      state <= IDLE;
      grant <= 2'd0;
      last  <= 2'(NUM_SRC-1);
      burst <= 8'd0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      burst <= burst_nxt;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      3'd0: begin
        rdata[NUM_SRC-1:0] = en;
        rdata[8]           = mode;
      end
      3'd1: begin
        rdata[NUM_SRC-1:0] = s_axis_tvalid_i;
        rdata[9:8]         = grant;
        rdata[12]          = (state == GRANT);
        rdata[23:16]       = burst;
      end
      3'd2:    rdata = beat_cnt;
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      en       <= '0;
      mode     <= 1'b0;
      beat_cnt <= 32'd0;
      data_o   <= 32'd0;
    end else begin
      if (wr_en && reg_sel == 3'd0) begin
        en   <= data_i[NUM_SRC-1:0];
        mode <= data_i[8];
      end
      // A clear beats a same-cycle increment.
      if (wr_en && reg_sel == 3'd2) beat_cnt <= 32'd0;
      else if (beat)                beat_cnt <= beat_cnt + 32'd1;
      data_o <= data_access_o ? rdata : 32'd0;
    end
  end
endmodule
